// File: rtl/shift_engine.sv
// shift_engine: parametrised serialiser/deserialiser with valid/ready load and
// output handshakes. Shifts LANES bits per step every SHIFT_DIV clocks.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   abort                synchronous clear back to IDLE
//   load_valid/ready     word input handshake (load_data, msb_first)
//   serial_in/out        LANES-wide serial lanes
//   shift_strobe         high in the cycle a shift step occurs
//   busy                 engine not IDLE
//   out_valid/ready      captured word handshake (out_data)
module shift_engine #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 1,
    parameter int SHIFT_DIV = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             abort,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             msb_first,
    input  logic [LANES-1:0] serial_in,
    output logic [LANES-1:0] serial_out,
    output logic             shift_strobe,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int NSTEPS = WIDTH / LANES;
    localparam int SW     = $clog2(NSTEPS + 1);
    localparam int DW     = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;

    if ((LANES < 1) || (WIDTH % LANES != 0) || (SHIFT_DIV < 1)) begin : g_bad_params
        $error("shift_engine: illegal WIDTH/LANES/SHIFT_DIV combination");
    end

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [SW-1:0]    steps_q;
    logic [DW-1:0]    div_q;
    logic             dir_q;
    logic             out_valid_q;

    logic             accept;
    logic             step;
    logic             div_last;
    logic             last_step;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;

    // A single-step word is replaced whole by the incoming lanes.
    if (WIDTH == LANES) begin : g_whole
        assign shl = serial_in;
        assign shr = serial_in;
    end else begin : g_part
        assign shl = {shreg_q[WIDTH-LANES-1:0], serial_in};
        assign shr = {serial_in, shreg_q[WIDTH-1:LANES]};
    end

    assign div_last   = (div_q == DW'(SHIFT_DIV - 1));
    assign last_step  = (steps_q == SW'(1));
    // Gated by reset_n so every output reads 0 while reset is held.
    assign load_ready = reset_n && (state_q == IDLE) && !abort;
    assign accept     = load_valid && load_ready;
    assign step       = (state_q == SHIFT) && div_last && !abort;

    assign shift_strobe = step;
    assign busy         = (state_q != IDLE);
    assign out_valid    = out_valid_q;
    assign out_data     = shreg_q;
    assign serial_out   = dir_q ? shreg_q[WIDTH-1 -: LANES] : shreg_q[LANES-1:0];

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (accept) state_d = SHIFT;
                SHIFT:   if (step && last_step) state_d = HOLD;
                HOLD:    if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q     <= '0;
            steps_q     <= '0;
            div_q       <= '0;
            dir_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (abort) begin
            // Partial word stays in shreg; only the output claim is dropped.
            out_valid_q <= 1'b0;
            div_q       <= '0;
        end else begin
            if (accept) begin
                shreg_q <= load_data;
                dir_q   <= msb_first;
                steps_q <= SW'(NSTEPS);
                div_q   <= '0;
            end else if (state_q == SHIFT) begin
                if (div_last) begin
                    div_q   <= '0;
                    shreg_q <= dir_q ? shl : shr;
                    steps_q <= steps_q - SW'(1);
                    if (last_step) begin
                        out_valid_q <= 1'b1;
                    end
                end else begin
                    div_q <= div_q + DW'(1);
                end
            end
            if ((state_q == HOLD) && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_engine.sv
// tb_shift_engine: directed and randomised checks of shift_engine in two
// configurations (W8/L1/D1 and W8/L2/D4) against a word-level model.
module tb_shift_engine;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       abort;
    logic       msb_first;
    logic [7:0] load_data;
    logic       lv   [2];
    logic       ordy [2];
    logic       lr   [2];
    logic       stb  [2];
    logic       bsy  [2];
    logic       ov   [2];
    logic [7:0] od   [2];
    logic [0:0] si_a;
    logic [0:0] so_a;
    logic [1:0] si_b;
    logic [1:0] so_b;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    shift_engine #(.WIDTH(8), .LANES(1), .SHIFT_DIV(1)) u_a (
        .clk(clk), .reset_n(reset_n), .abort(abort),
        .load_valid(lv[0]), .load_ready(lr[0]), .load_data(load_data),
        .msb_first(msb_first), .serial_in(si_a), .serial_out(so_a),
        .shift_strobe(stb[0]), .busy(bsy[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .out_data(od[0])
    );

    shift_engine #(.WIDTH(8), .LANES(2), .SHIFT_DIV(4)) u_b (
        .clk(clk), .reset_n(reset_n), .abort(abort),
        .load_valid(lv[1]), .load_ready(lr[1]), .load_data(load_data),
        .msb_first(msb_first), .serial_in(si_b), .serial_out(so_b),
        .shift_strobe(stb[1]), .busy(bsy[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .out_data(od[1])
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] so_of(input int u);
        return (u != 0) ? so_b : {1'b0, so_a};
    endfunction

    task automatic set_si(input int u, input logic [1:0] v);
        if (u != 0) si_b = v;
        else si_a = v[0:0];
    endtask

    task automatic idle_outs(input int u, input string tag);
        chk({tag, "_busy"}, 8'(bsy[u]), 8'h00);
        chk({tag, "_ov"}, 8'(ov[u]), 8'h00);
        chk({tag, "_lr"}, 8'(lr[u]), 8'h01);
    endtask

    task automatic start(input int u, input logic [7:0] d, input logic m);
        @(negedge clk);
        chk("start_lr", 8'(lr[u]), 8'h01);
        load_data = d;
        msb_first = m;
        lv[u] = 1'b1;
        @(posedge clk);
        #1;
        lv[u] = 1'b0;
        // msb_first must only matter at accept time.
        msb_first = ~m;
    endtask

    // mode 0: random serial_in, 1: loopback of serial_out, 2: constant cval
    task automatic xfer(input int u, input logic [7:0] d, input logic m,
                        input int mode, input logic [1:0] cval, input int hold);
        int L;
        int D;
        int N;
        int pos;
        int k;
        logic [7:0] mask;
        logic [7:0] exp_w;
        logic [1:0] eo;
        logic [1:0] v;
        L = (u != 0) ? 2 : 1;
        D = (u != 0) ? 4 : 1;
        N = 8 / L;
        mask = 8'((1 << L) - 1);
        exp_w = 8'h00;
        start(u, d, m);
        for (int c = 1; c <= N * D; c++) begin
            @(negedge clk);
            chk("busy_shift", 8'(bsy[u]), 8'h01);
            chk("ov_shift", 8'(ov[u]), 8'h00);
            chk("strobe", 8'(stb[u]), 8'((c % D) == 0));
            if ((c % D) == 0) begin
                k = c / D - 1;
                // Lane group k leaves from, and the k-th capture lands in, the same slot.
                pos = m ? 8 - L * (k + 1) : L * k;
                eo = 2'((d >> pos) & mask);
                chk("serial_out", 8'(so_of(u)), 8'(eo));
                case (mode)
                    1: v = eo;
                    2: v = cval;
                    default: v = 2'($urandom & 32'(mask));
                endcase
                set_si(u, v);
                exp_w = exp_w | (8'(v) << pos);
            end
            @(posedge clk);
        end
        @(negedge clk);
        chk("ov_rise", 8'(ov[u]), 8'h01);
        chk("out_data", od[u], exp_w);
        chk("lr_hold", 8'(lr[u]), 8'h00);
        chk("strobe_hold", 8'(stb[u]), 8'h00);
        for (int h = 0; h < hold; h++) begin
            load_data = 8'($urandom);
            lv[u] = 1'b1;
            @(negedge clk);
            chk("bp_ov", 8'(ov[u]), 8'h01);
            chk("bp_data", od[u], exp_w);
            chk("bp_lr", 8'(lr[u]), 8'h00);
        end
        lv[u] = 1'b0;
        ordy[u] = 1'b1;
        @(negedge clk);
        ordy[u] = 1'b0;
        idle_outs(u, "after_hs");
    endtask

    initial begin
        reset_n = 1'b0;
        abort = 1'b0;
        msb_first = 1'b0;
        load_data = 8'h00;
        si_a = '0;
        si_b = '0;
        for (int i = 0; i < 2; i++) begin
            lv[i] = 1'b0;
            ordy[i] = 1'b0;
        end

        #12;
        for (int i = 0; i < 2; i++) begin
            chk("rst_lr_low", 8'(lr[i]), 8'h00);
            chk("rst_od", od[i], 8'h00);
            chk("rst_ov", 8'(ov[i]), 8'h00);
            chk("rst_strobe", 8'(stb[i]), 8'h00);
        end
        chk("rst_so_a", 8'(so_a), 8'h00);
        chk("rst_so_b", 8'(so_b), 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        idle_outs(0, "rel_a");
        idle_outs(1, "rel_b");

        xfer(0, 8'hA5, 1'b1, 1, 2'b00, 0);
        xfer(0, 8'h00, 1'b0, 2, 2'b01, 0);
        xfer(1, 8'h3C, 1'b1, 2, 2'b01, 0);
        xfer(1, 8'($urandom), 1'($urandom), 0, 2'b00, 10);

        repeat (6) begin
            for (int u = 0; u < 2; u++) begin
                xfer(u, 8'($urandom), 1'($urandom), 0, 2'b00,
                     int'($urandom_range(0, 3)));
            end
        end

        // abort after the 3rd step, with a competing load in the same cycle
        start(0, 8'($urandom), 1'b1);
        repeat (3) begin
            @(negedge clk);
            si_a = 1'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        abort = 1'b1;
        lv[0] = 1'b1;
        load_data = 8'h5A;
        #1;
        chk("abort_lr", 8'(lr[0]), 8'h00);
        chk("abort_strobe", 8'(stb[0]), 8'h00);
        @(negedge clk);
        abort = 1'b0;
        lv[0] = 1'b0;
        #1;
        idle_outs(0, "post_abort");
        xfer(0, 8'h96, 1'b0, 0, 2'b00, 1);

        // asynchronous reset between edges in the middle of a shift
        start(1, 8'hC3, 1'b1);
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_so", 8'(so_b), 8'h00);
        chk("arst_strobe", 8'(stb[1]), 8'h00);
        chk("arst_busy", 8'(bsy[1]), 8'h00);
        chk("arst_ov", 8'(ov[1]), 8'h00);
        chk("arst_od", od[1], 8'h00);
        chk("arst_lr", 8'(lr[1]), 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        idle_outs(1, "arst_rel");
        xfer(1, 8'h81, 1'b0, 0, 2'b00, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
